// File: rtl/hilo_muldiv_unit.sv
// EX-stage HI/LO unit: 1-cycle MULT/MULTU/MADD/MSUB/MTHI/MTLO, DATA_W-cycle restoring DIV/DIVU.
// Busy (registered) stalls upstream for the whole divide; ops presented while busy are dropped.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Valid,
  input  logic [3:0]        Op,
  input  logic [DATA_W-1:0] RsData,
  input  logic [DATA_W-1:0] RtData,
  input  logic              Flush,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  output logic              Busy,
  output logic              DivZero
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_DIVIDE = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MSUB  = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_DIVU  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [0:0]          state;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   div_rem;
  logic [DATA_W-1:0]   div_quot;
  logic [DATA_W-1:0]   div_dvsr;
  logic                q_neg;
  logic                r_neg;

  logic                accept;
  logic                div_signed;
  logic                rs_neg;
  logic                rt_neg;
  logic [DATA_W-1:0]   rs_abs;
  logic [DATA_W-1:0]   rt_abs;
  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic [2*DATA_W-1:0] hilo;

  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     diff;
  logic                sub_ok;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quot_nxt;
  logic [DATA_W-1:0]   q_fin;
  logic [DATA_W-1:0]   r_fin;

  assign Busy   = (state == S_DIVIDE);
  assign accept = Valid && (state == S_IDLE) && !Flush;

  // Sign-extended operands multiplied modulo 2^(2W) give the two's-complement signed product.
  assign prod_s = {{DATA_W{RsData[DATA_W-1]}}, RsData} * {{DATA_W{RtData[DATA_W-1]}}, RtData};
  assign prod_u = {{DATA_W{1'b0}}, RsData} * {{DATA_W{1'b0}}, RtData};
  assign hilo   = {Hi, Lo};

  assign div_signed = (Op == OP_DIV);
  assign rs_neg     = div_signed && RsData[DATA_W-1];
  assign rt_neg     = div_signed && RtData[DATA_W-1];
  assign rs_abs     = rs_neg ? -RsData : RsData;
  assign rt_abs     = rt_neg ? -RtData : RtData;

  // Restoring step: the dividend shifts out of div_quot into the partial remainder.
  assign rem_sh   = {div_rem, div_quot[DATA_W-1]};
  assign diff     = rem_sh - {1'b0, div_dvsr};
  assign sub_ok   = !diff[DATA_W];
  assign rem_nxt  = sub_ok ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
  assign quot_nxt = {div_quot[DATA_W-2:0], sub_ok};
  assign q_fin    = q_neg ? -quot_nxt : quot_nxt;
  assign r_fin    = r_neg ? -rem_nxt : rem_nxt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      count    <= '0;
      div_rem  <= '0;
      div_quot <= '0;
      div_dvsr <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
      DivZero  <= 1'b0;
    end else begin
      DivZero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (Op)
              OP_MULT:  {Hi, Lo} <= prod_s;
              OP_MULTU: {Hi, Lo} <= prod_u;
              OP_MADD:  {Hi, Lo} <= hilo + prod_s;
              OP_MSUB:  {Hi, Lo} <= hilo - prod_s;
              OP_MTHI:  Hi <= RsData;
              OP_MTLO:  Lo <= RsData;
              OP_DIV, OP_DIVU: begin
                if (RtData == '0) begin
                  DivZero <= 1'b1;
                end else begin
                  state    <= S_DIVIDE;
                  count    <= '0;
                  div_rem  <= '0;
                  div_quot <= rs_abs;
                  div_dvsr <= rt_abs;
                  q_neg    <= rs_neg ^ rt_neg;
                  r_neg    <= rs_neg;
                end
              end
              default: ;
            endcase
          end
        end
        S_DIVIDE: begin
          if (Flush) begin
            state <= S_IDLE;
            count <= '0;
          end else begin
            div_rem  <= rem_nxt;
            div_quot <= quot_nxt;
            count    <= count + 1'b1;
            if (count == LAST_STEP) begin
              Hi    <= r_fin;
              Lo    <= q_fin;
              state <= S_IDLE;
              count <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
